// File: rtl/lcd_msg_arbiter.sv
// Round-robin arbiter sharing the two LCD line buses between several requesters.
// Each winner's message is latched and held for a fixed dwell time, then one idle cycle follows.
module lcd_msg_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter logic [31:0] DWELL_CYCLES = 32'd50000000,
    parameter logic [7:0]  BLANK_CHAR   = 8'h20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*128-1:0]   msg_line1,
    input  logic [NUM_REQ*128-1:0]   msg_line2,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     done,
    output logic                     busy,
    output logic [2:0]               active_id,
    output logic [127:0]             first_line,
    output logic [127:0]             second_line
);

    localparam logic [127:0] BLANK_LINE = {16{BLANK_CHAR}};
    localparam logic [2:0]   LAST_ID    = 3'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, DWELL, RELEASE} state_t;

    state_t               state, state_next;
    logic [2:0]           ptr, ptr_next;
    logic [31:0]          count, count_next;
    logic [NUM_REQ-1:0]   grant_next;
    logic                 done_next, busy_next;
    logic [2:0]           active_id_next;
    logic [127:0]         first_line_next, second_line_next;

    logic [7:0]           req_pad;
    logic                 found;
    logic [2:0]           winner;
    logic [3:0]           idx;
    logic [127:0]         sel_line1, sel_line2;

    assign req_pad = 8'(req);

    // Search ptr, ptr+1, ... wrapping, and take the first asserted request.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NUM_REQ)) begin
                idx = idx - 4'(NUM_REQ);
            end
            if (!found && req_pad[idx[2:0]]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

    always_comb begin
        sel_line1 = msg_line1[127:0];
        sel_line2 = msg_line2[127:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == 3'(i)) begin
                sel_line1 = msg_line1[i*128 +: 128];
                sel_line2 = msg_line2[i*128 +: 128];
            end
        end
    end

    always_comb begin
        state_next       = state;
        ptr_next         = ptr;
        count_next       = count;
        grant_next       = grant;
        done_next        = done;
        busy_next        = busy;
        active_id_next   = active_id;
        first_line_next  = first_line;
        second_line_next = second_line;

        unique case (state)
            IDLE: begin
                if (found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        grant_next[i] = (winner == 3'(i));
                    end
                    active_id_next   = winner;
                    busy_next        = 1'b1;
                    first_line_next  = sel_line1;
                    second_line_next = sel_line2;
                    count_next       = '0;
                    state_next       = DWELL;
                end
            end
            DWELL: begin
                // No abort path: req and message changes are ignored until the dwell expires.
                if (count == DWELL_CYCLES - 32'd1) begin
                    grant_next = '0;
                    done_next  = 1'b1;
                    ptr_next   = (active_id == LAST_ID) ? 3'd0 : active_id + 3'd1;
                    state_next = RELEASE;
                end else begin
                    count_next = count + 32'd1;
                end
            end
            RELEASE: begin
                done_next  = 1'b0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            count       <= '0;
            grant       <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            active_id   <= '0;
            first_line  <= BLANK_LINE;
            second_line <= BLANK_LINE;
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            count       <= count_next;
            grant       <= grant_next;
            done        <= done_next;
            busy        <= busy_next;
            active_id   <= active_id_next;
            first_line  <= first_line_next;
            second_line <= second_line_next;
        end
    end

endmodule

// File: doc/lcd_msg_arbiter.md
Name: lcd_msg_arbiter

Overview:
Shares the single LCD text path (the two 128-bit line buses feeding the LCD driver) between NUM_REQ requesters. Each requester supplies a full two-line, 32-character message. Winners are picked round-robin. The arbiter latches the winner's message onto the LCD line buses and holds it for a guaranteed minimum dwell time before the next requester may take over. It sits between application logic and the LCD driver's first_line/second_line inputs.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- DWELL_CYCLES, 50000000, clk cycles each granted message is held; legal range 1..2^32-1.
- BLANK_CHAR, 8'h20, ASCII code used to fill both lines after reset.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  request per requester; level-sensitive.
- msg_line1  input  NUM_REQ*128  requester i's first line at [i*128 +: 128]; bits [127:120] hold the leftmost character.
- msg_line2  input  NUM_REQ*128  requester i's second line, same packing as msg_line1.
- grant  output  NUM_REQ  one-hot; high for exactly DWELL_CYCLES cycles per grant.
- done  output  1  one-cycle pulse marking the end of a grant.
- busy  output  1  high while a grant is in progress, including the release cycle.
- active_id  output  3  index of the current or most recent winner.
- first_line  output  128  to the LCD driver's first_line input.
- second_line  output  128  to the LCD driver's second_line input.

Behaviour:
- Reset values, applied immediately while reset is high and independent of clk:
  - first_line and second_line = {16{BLANK_CHAR}}
  - grant = 0, done = 0, busy = 0, active_id = 0
  - round-robin pointer ptr = 0, dwell counter = 0, state = IDLE
- Reset asserted mid-grant aborts the grant: grant drops, no done pulse is issued, and the display blanks.
- The state machine has three states: IDLE, DWELL and RELEASE.
- IDLE:
  - With req == 0, the block holds; line outputs keep their last message (they are not blanked).
  - With any req bit set, the winner is the first asserted index searching ptr, ptr+1, ... and wrapping modulo NUM_REQ.
  - On that same edge:
    - grant <= onehot(winner), active_id <= winner, busy <= 1
    - first_line <= msg_line1 slice of the winner; second_line <= msg_line2 slice of the winner
    - counter <= 0; state goes to DWELL
  - Latency from req sampled high to grant high is 1 cycle.
- DWELL:
  - The counter increments every cycle.
  - When counter == DWELL_CYCLES-1: grant <= 0, done <= 1, ptr <= (winner+1) mod NUM_REQ, state goes to RELEASE.
  - grant is therefore high for exactly DWELL_CYCLES cycles.
  - Changes on msg_line1/msg_line2 are ignored (the message is latched).
  - req deasserting early is ignored: minimum display time is guaranteed and there is no abort path.
  - New req bits from other requesters wait.
- RELEASE: done <= 0, busy <= 0, state goes to IDLE. This forces one idle cycle between grants.
- Back-to-back: if done rises at edge t, the earliest next grant rises at edge t+2.
- A requester still holding req after its done re-competes, but ptr has advanced past it, so other pending requesters win first.
- With a single persistent requester it is re-granted repeatedly, each time with a fresh latch of its inputs.
- DWELL_CYCLES = 1: grant is high for one cycle; done rises on the next edge.
- The counter is 32 bits and never wraps, because it resets on every grant.
- The winner's message is copied bit-exact, with no character translation; the LCD driver owns nibble sequencing.

Test Plan:
- Reset (DWELL_CYCLES=4): assert reset mid-cycle then release → first_line and second_line = 128'h2020...20 immediately; grant = 0, busy = 0, done = 0, active_id = 0.
- Single request (DWELL_CYCLES=4): req=4'b0010, msg_line1 slice1="HELLO WORLD     ", slice2="LINE TWO        " →
  - grant=4'b0010 one cycle later, held 4 cycles; active_id=1
  - first_line/second_line match the slices
  - done pulses 1 cycle as grant falls; busy falls 1 cycle later
- Round-robin fairness: req=4'b1111 held constantly → grant order 0001, 0010, 0100, 1000, 0001; each grant separated by exactly one idle cycle after done.
- Latch integrity: during DWELL, change the granted requester's msg_line1 and drop its req → first_line unchanged; grant still lasts the full 4 cycles; done is issued.
- Reset mid-grant: assert reset on cycle 2 of DWELL → grant = 0 immediately, no done pulse, lines blank; after release with req=4'b0100, requester 2 wins (ptr restarted at 0).
- DWELL_CYCLES=1 edge case: req=4'b0001 persistent → grant high 1 cycle, done next edge, re-grant 2 edges after done, repeating with period 3 cycles.
